// File: rtl/jxj_pkg.sv
// rtl/jxj_pkg.sv - shared jxj transaction layout and pack/unpack helpers
package jxj_pkg;

    localparam int JXJ_TXN_BYTES  = 8;
    localparam int JXJ_CTL_RD_BIT = 4;

    typedef struct packed {
        logic        rd;
        logic [23:0] addr;
        logic [31:0] data;
    } jxj_txn_t;

    function automatic logic [63:0] jxj_pack(input jxj_txn_t t);
        logic [7:0] ctl;
        ctl = 8'h00;
        ctl[JXJ_CTL_RD_BIT] = t.rd;
        return {ctl, t.addr, t.data};
    endfunction

    function automatic jxj_txn_t jxj_unpack(input logic [63:0] v);
        jxj_txn_t t;
        t.rd   = v[56 + JXJ_CTL_RD_BIT];
        t.addr = v[55:32];
        t.data = v[31:0];
        return t;
    endfunction

endpackage

// File: rtl/jxj_rx_deframe.sv
// rtl/jxj_rx_deframe.sv - reply byte deframer: collects 8-byte transactions into responses
module jxj_rx_deframe
    import jxj_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    input  logic [7:0]  rx_din,
    input  logic        rx_stb,
    output logic [2:0]  byte_cnt_nxt,
    output logic [4:0]  txn_cnt_nxt,
    output logic        resp_valid,
    output logic        resp_rd,
    output logic [23:0] resp_addr,
    output logic [31:0] resp_data
);

    logic [63:0] rx_sh;
    logic [63:0] rx_sh_nxt;
    logic [2:0]  byte_cnt;
    logic [4:0]  txn_cnt;
    logic        take;
    logic        txn_done;
    jxj_txn_t    rx_txn;

    // Next-state counts are exported so an rx_end landing on the final byte sees that byte.
    always_comb begin
        take         = en & rx_stb;
        txn_done     = take & (byte_cnt == 3'(JXJ_TXN_BYTES - 1));
        rx_sh_nxt    = {rx_sh[55:0], rx_din};
        byte_cnt_nxt = take ? byte_cnt + 3'd1 : byte_cnt;
        txn_cnt_nxt  = (txn_done && txn_cnt != 5'h1f) ? txn_cnt + 5'd1 : txn_cnt;
        rx_txn       = jxj_unpack(rx_sh_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sh      <= '0;
            byte_cnt   <= '0;
            txn_cnt    <= '0;
            resp_valid <= 1'b0;
            resp_rd    <= 1'b0;
            resp_addr  <= '0;
            resp_data  <= '0;
        end else begin
            resp_valid <= txn_done;
            if (take) begin
                rx_sh <= rx_sh_nxt;
            end
            if (txn_done) begin
                resp_rd   <= rx_txn.rd;
                resp_addr <= rx_txn.addr;
                resp_data <= rx_txn.data;
            end
            if (clr) begin
                byte_cnt <= '0;
                txn_cnt  <= '0;
            end else begin
                byte_cnt <= byte_cnt_nxt;
                txn_cnt  <= txn_cnt_nxt;
            end
        end
    end

endmodule

// File: rtl/jxj_host.sv
// rtl/jxj_host.sv - jxj link initiator: batches localbus commands into packets, checks replies
module jxj_host
    import jxj_pkg::*;
#(
    parameter int BATCH   = 4,
    parameter int TIMEOUT = 4095
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rd,
    input  logic [23:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic [7:0]  tx_dout,
    output logic        tx_stb,
    input  logic        tx_rdy,
    output logic        tx_end,
    input  logic [7:0]  rx_din,
    input  logic        rx_stb,
    input  logic        rx_end,
    output logic        resp_valid,
    output logic        resp_rd,
    output logic [23:0] resp_addr,
    output logic [31:0] resp_data,
    output logic        busy,
    output logic        err_len,
    output logic        err_tmo
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_WAIT = 2'd3;

    logic [1:0]  state;
    logic [63:0] tx_sh;
    logic [2:0]  tx_byte;
    logic [3:0]  txn_cnt;
    logic [4:0]  sent_n;
    logic [11:0] tmo;
    logic        b7_seen;
    logic        cont_q;

    logic        last_byte;
    logic        room;
    logic        cont_now;
    logic        xfer;
    logic        cmd_take;
    logic        rx_en;
    logic        rx_clr;
    logic        len_bad;
    logic        tmo_hit;
    logic [2:0]  rx_byte_nxt;
    logic [4:0]  rx_txn_nxt;
    jxj_txn_t    cmd_txn;
    logic [63:0] cmd_word;

    // Continuation is frozen the first cycle byte 7 is shown so tx_end never changes under a stall.
    always_comb begin
        last_byte   = (state == ST_SEND) && (tx_byte == 3'(JXJ_TXN_BYTES - 1));
        room        = ({1'b0, txn_cnt} + 5'd1) < 5'(BATCH);
        cont_now    = b7_seen ? cont_q : (cmd_valid & room);
        xfer        = (state == ST_SEND) & tx_rdy;
        tx_stb      = (state == ST_SEND);
        tx_dout     = (state == ST_SEND) ? tx_sh[63:56] : 8'h00;
        tx_end      = last_byte & ~cont_now;
        cmd_ready   = ~rst & ((state == ST_IDLE) | (last_byte & cont_now & tx_rdy));
        cmd_take    = cmd_valid & cmd_ready;
        busy        = (state != ST_IDLE);
        cmd_txn.rd   = cmd_rd;
        cmd_txn.addr = cmd_addr;
        cmd_txn.data = cmd_rd ? 32'h0 : cmd_wdata;
        cmd_word    = jxj_pack(cmd_txn);
        rx_en       = (state == ST_WAIT);
        len_bad     = (rx_byte_nxt != 3'd0) || (rx_txn_nxt != sent_n);
        tmo_hit     = rx_en & ~rx_end & (tmo == 12'(TIMEOUT - 1));
        rx_clr      = (xfer & tx_end) | (rx_en & rx_end) | tmo_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            tx_sh   <= '0;
            tx_byte <= '0;
            txn_cnt <= '0;
            sent_n  <= '0;
            tmo     <= '0;
            b7_seen <= 1'b0;
            cont_q  <= 1'b0;
            err_len <= 1'b0;
            err_tmo <= 1'b0;
        end else begin
            err_len <= 1'b0;
            err_tmo <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_take) begin
                        tx_sh   <= cmd_word;
                        tx_byte <= '0;
                        txn_cnt <= '0;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state <= ST_SEND;
                end
                ST_SEND: begin
                    if (last_byte) begin
                        b7_seen <= 1'b1;
                        cont_q  <= cont_now;
                    end
                    if (xfer) begin
                        b7_seen <= 1'b0;
                        if (!last_byte) begin
                            tx_sh   <= tx_sh << 8;
                            tx_byte <= tx_byte + 3'd1;
                        end else if (cmd_take) begin
                            tx_sh   <= cmd_word;
                            tx_byte <= '0;
                            txn_cnt <= txn_cnt + 4'd1;
                        end else begin
                            tx_byte <= '0;
                            sent_n  <= {1'b0, txn_cnt} + 5'd1;
                            tmo     <= '0;
                            state   <= ST_WAIT;
                        end
                    end
                end
                default: begin
                    if (rx_end) begin
                        err_len <= len_bad;
                        state   <= ST_IDLE;
                    end else if (tmo_hit) begin
                        err_tmo <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        tmo <= tmo + 12'd1;
                    end
                end
            endcase
        end
    end

    jxj_rx_deframe u_rx (
        .clk          (clk),
        .rst          (rst),
        .en           (rx_en),
        .clr          (rx_clr),
        .rx_din       (rx_din),
        .rx_stb       (rx_stb),
        .byte_cnt_nxt (rx_byte_nxt),
        .txn_cnt_nxt  (rx_txn_nxt),
        .resp_valid   (resp_valid),
        .resp_rd      (resp_rd),
        .resp_addr    (resp_addr),
        .resp_data    (resp_data)
    );

endmodule

// File: tb/tb_jxj_host.sv
// tb/tb_jxj_host.sv - directed self-checking bench for jxj_host
module tb_jxj_host;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_rd = 1'b0;
    logic [23:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [7:0]  tx_dout;
    logic        tx_stb;
    logic        tx_rdy = 1'b1;
    logic        tx_end;
    logic [7:0]  rx_din = '0;
    logic        rx_stb = 1'b0;
    logic        rx_end = 1'b0;
    logic        resp_valid;
    logic        resp_rd;
    logic [23:0] resp_addr;
    logic [31:0] resp_data;
    logic        busy;
    logic        err_len;
    logic        err_tmo;

    int checks = 0;
    int errors = 0;

    logic [7:0]  tx_bytes[$];
    bit          tx_ends[$];
    int          pkt_cnt = 0;
    logic        rsp_rd_q[$];
    logic [23:0] rsp_addr_q[$];
    logic [31:0] rsp_data_q[$];
    int          err_len_cnt = 0;
    int          err_tmo_cnt = 0;
    int          rx_pos = 0;
    bit          stall_en = 1'b0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_dout = '0;

    logic        c_rd[8];
    logic [23:0] c_addr[8];
    logic [31:0] c_data[8];

    always #5 clk = ~clk;

    jxj_host #(.BATCH(4), .TIMEOUT(100)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_rd     (cmd_rd),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .tx_dout    (tx_dout),
        .tx_stb     (tx_stb),
        .tx_rdy     (tx_rdy),
        .tx_end     (tx_end),
        .rx_din     (rx_din),
        .rx_stb     (rx_stb),
        .rx_end     (rx_end),
        .resp_valid (resp_valid),
        .resp_rd    (resp_rd),
        .resp_addr  (resp_addr),
        .resp_data  (resp_data),
        .busy       (busy),
        .err_len    (err_len),
        .err_tmo    (err_tmo)
    );

    always @(posedge clk) begin
        #1;
        tx_rdy = stall_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (tx_stb !== 1'b1 || tx_dout !== prev_dout) begin
                    errors++;
                    $display("FAIL stall_hold: tx_stb=%b tx_dout=%h, required tx_stb=1 tx_dout=%h",
                             tx_stb, tx_dout, prev_dout);
                end
            end
            prev_stall = tx_stb & ~tx_rdy;
            prev_dout  = tx_dout;
            if (tx_stb && tx_rdy) begin
                tx_bytes.push_back(tx_dout);
                tx_ends.push_back(tx_end);
                if (tx_end) pkt_cnt++;
            end
            if (resp_valid) begin
                rsp_rd_q.push_back(resp_rd);
                rsp_addr_q.push_back(resp_addr);
                rsp_data_q.push_back(resp_data);
            end
            if (err_len) err_len_cnt++;
            if (err_tmo) err_tmo_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        tx_bytes.delete();
        tx_ends.delete();
        rsp_rd_q.delete();
        rsp_addr_q.delete();
        rsp_data_q.delete();
        pkt_cnt     = 0;
        err_len_cnt = 0;
        err_tmo_cnt = 0;
        rx_pos      = 0;
    endtask

    task automatic drive_cmds(input int n);
        int i;
        int cyc;
        bit hs;
        i = 0;
        cyc = 0;
        while (i < n && cyc < 2000) begin
            cmd_valid = 1'b1;
            cmd_rd    = c_rd[i];
            cmd_addr  = c_addr[i];
            cmd_wdata = c_data[i];
            @(negedge clk);
            hs = cmd_ready;
            tick();
            if (hs) i++;
            cyc++;
        end
        cmd_valid = 1'b0;
        cmd_rd    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        checks++;
        if (i != n) begin
            errors++;
            $display("FAIL cmd_accept: accepted %0d, required %0d", i, n);
        end
    endtask

    // Echo each finished packet back; read transactions get rdata in place of the data bytes.
    task automatic respond(input int npkt, input logic [31:0] rdata, input int trunc);
        int cyc;
        int n;
        int k;
        bit is_rd;
        bit fin;
        logic [7:0] b;
        for (int p = 0; p < npkt; p++) begin
            cyc = 0;
            n = 0;
            is_rd = 1'b0;
            fin = 1'b0;
            while (pkt_cnt <= p && cyc < 3000) begin
                tick();
                cyc++;
            end
            if (pkt_cnt <= p) begin
                checks++;
                errors++;
                $display("FAIL pkt_wait: packets seen %0d, required %0d", pkt_cnt, p + 1);
                return;
            end
            while (!fin && rx_pos < tx_bytes.size()) begin
                k = n % 8;
                b = tx_bytes[rx_pos];
                if (k == 0) is_rd = b[4];
                if (is_rd && k >= 4) b = rdata[8*(7-k) +: 8];
                if (trunc < 0 || n < trunc) begin
                    rx_stb = 1'b1;
                    rx_din = b;
                    tick();
                end
                fin = tx_ends[rx_pos];
                n++;
                rx_pos++;
            end
            rx_stb = 1'b0;
            rx_din = '0;
            rx_end = 1'b1;
            tick();
            rx_end = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if ({tx_stb, tx_end, tx_dout, cmd_ready, busy, resp_valid, err_len, err_tmo} !== 15'h0) begin
            errors++;
            $display("FAIL reset_ctl: stb=%b end=%b dout=%h rdy=%b busy=%b rv=%b el=%b et=%b, required all 0",
                     tx_stb, tx_end, tx_dout, cmd_ready, busy, resp_valid, err_len, err_tmo);
        end
        checks++;
        if ({resp_rd, resp_addr, resp_data} !== 57'h0) begin
            errors++;
            $display("FAIL reset_resp: rd=%b addr=%h data=%h, required 0", resp_rd, resp_addr, resp_data);
        end
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: cmd_ready=%b busy=%b, required 1 0", cmd_ready, busy);
        end
        tick();
    endtask

    task automatic test_single_write();
        logic [7:0] exp_b[8];
        exp_b = '{8'h00, 8'h00, 8'h01, 8'h23, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        clear_logs();
        c_rd[0] = 1'b0; c_addr[0] = 24'h000123; c_data[0] = 32'hDEADBEEF;
        fork
            drive_cmds(1);
            respond(1, 32'h0, -1);
        join
        repeat (3) tick();
        checks++;
        if (tx_bytes.size() != 8) begin
            errors++;
            $display("FAIL wr_len: %0d bytes, required 8", tx_bytes.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                checks++;
                if (tx_bytes[j] !== exp_b[j] || tx_ends[j] !== (j == 7)) begin
                    errors++;
                    $display("FAIL wr_byte%0d: %h end=%b, required %h end=%b", j, tx_bytes[j], tx_ends[j], exp_b[j], j == 7);
                end
            end
        end
        checks++;
        if (rsp_rd_q.size() != 1) begin
            errors++;
            $display("FAIL wr_resp_cnt: %0d, required 1", rsp_rd_q.size());
        end else begin
            checks++;
            if (rsp_rd_q[0] !== 1'b0 || rsp_addr_q[0] !== 24'h000123 || rsp_data_q[0] !== 32'hDEADBEEF) begin
                errors++;
                $display("FAIL wr_resp: rd=%b addr=%h data=%h, required 0 000123 deadbeef",
                         rsp_rd_q[0], rsp_addr_q[0], rsp_data_q[0]);
            end
        end
        checks++;
        if (err_len_cnt != 0 || err_tmo_cnt != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wr_status: err_len=%0d err_tmo=%0d busy=%b, required 0 0 0", err_len_cnt, err_tmo_cnt, busy);
        end
    endtask

    task automatic test_single_read();
        logic [7:0] exp_b[8];
        exp_b = '{8'h10, 8'h80, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        clear_logs();
        c_rd[0] = 1'b1; c_addr[0] = 24'h800004; c_data[0] = 32'hFFFFFFFF;
        fork
            drive_cmds(1);
            respond(1, 32'h12345678, -1);
        join
        repeat (3) tick();
        checks++;
        if (tx_bytes.size() != 8) begin
            errors++;
            $display("FAIL rd_len: %0d bytes, required 8", tx_bytes.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                checks++;
                if (tx_bytes[j] !== exp_b[j] || tx_ends[j] !== (j == 7)) begin
                    errors++;
                    $display("FAIL rd_byte%0d: %h end=%b, required %h end=%b", j, tx_bytes[j], tx_ends[j], exp_b[j], j == 7);
                end
            end
        end
        checks++;
        if (rsp_rd_q.size() != 1) begin
            errors++;
            $display("FAIL rd_resp_cnt: %0d, required 1", rsp_rd_q.size());
        end else begin
            checks++;
            if (rsp_rd_q[0] !== 1'b1 || rsp_addr_q[0] !== 24'h800004 || rsp_data_q[0] !== 32'h12345678) begin
                errors++;
                $display("FAIL rd_resp: rd=%b addr=%h data=%h, required 1 800004 12345678",
                         rsp_rd_q[0], rsp_addr_q[0], rsp_data_q[0]);
            end
        end
    endtask

    task automatic run_batch(input bit stall, input string tag);
        logic [63:0] w;
        logic [31:0] exp_d;
        int k;
        bit e;
        clear_logs();
        for (int i = 0; i < 6; i++) begin
            c_rd[i]   = (i == 2) || (i == 5);
            c_addr[i] = 24'hA00000 | 24'(i);
            c_data[i] = 32'h11111111 * 32'(i + 1);
        end
        stall_en = stall;
        fork
            drive_cmds(6);
            respond(2, 32'hCAFE0000, -1);
        join
        stall_en = 1'b0;
        repeat (4) tick();
        checks++;
        if (tx_bytes.size() != 48 || pkt_cnt != 2) begin
            errors++;
            $display("FAIL %s_len: %0d bytes %0d packets, required 48 2", tag, tx_bytes.size(), pkt_cnt);
        end else begin
            for (int i = 0; i < 6; i++) begin
                w = {3'b000, c_rd[i], 4'b0000, c_addr[i], (c_rd[i] ? 32'h0 : c_data[i])};
                for (int j = 0; j < 8; j++) begin
                    k = i * 8 + j;
                    e = (k == 31) || (k == 47);
                    checks++;
                    if (tx_bytes[k] !== w[63-8*j -: 8] || tx_ends[k] !== e) begin
                        errors++;
                        $display("FAIL %s_byte%0d: %h end=%b, required %h end=%b", tag, k, tx_bytes[k], tx_ends[k], w[63-8*j -: 8], e);
                    end
                end
            end
        end
        checks++;
        if (rsp_rd_q.size() != 6) begin
            errors++;
            $display("FAIL %s_resp_cnt: %0d, required 6", tag, rsp_rd_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                exp_d = c_rd[i] ? 32'hCAFE0000 : c_data[i];
                checks++;
                if (rsp_rd_q[i] !== c_rd[i] || rsp_addr_q[i] !== c_addr[i] || rsp_data_q[i] !== exp_d) begin
                    errors++;
                    $display("FAIL %s_resp%0d: rd=%b addr=%h data=%h, required %b %h %h", tag, i,
                             rsp_rd_q[i], rsp_addr_q[i], rsp_data_q[i], c_rd[i], c_addr[i], exp_d);
                end
            end
        end
        checks++;
        if (err_len_cnt != 0 || err_tmo_cnt != 0) begin
            errors++;
            $display("FAIL %s_err: err_len=%0d err_tmo=%0d, required 0 0", tag, err_len_cnt, err_tmo_cnt);
        end
    endtask

    task automatic test_back_to_back();
        run_batch(1'b0, "b2b");
    endtask

    task automatic test_stall();
        run_batch(1'b1, "stall");
    endtask

    task automatic test_truncated();
        clear_logs();
        c_rd[0] = 1'b0; c_addr[0] = 24'h000010; c_data[0] = 32'hAAAA5555;
        c_rd[1] = 1'b0; c_addr[1] = 24'h000014; c_data[1] = 32'h5555AAAA;
        fork
            drive_cmds(2);
            respond(1, 32'h0, 13);
        join
        @(negedge clk);
        checks++;
        if (err_len !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL trunc_end: err_len=%b busy=%b, required 1 0", err_len, busy);
        end
        repeat (3) tick();
        checks++;
        if (rsp_rd_q.size() != 1 || err_len_cnt != 1 || err_tmo_cnt != 0) begin
            errors++;
            $display("FAIL trunc_counts: resp=%0d err_len=%0d err_tmo=%0d, required 1 1 0",
                     rsp_rd_q.size(), err_len_cnt, err_tmo_cnt);
        end else begin
            checks++;
            if (rsp_addr_q[0] !== 24'h000010 || rsp_data_q[0] !== 32'hAAAA5555) begin
                errors++;
                $display("FAIL trunc_resp: addr=%h data=%h, required 000010 aaaa5555", rsp_addr_q[0], rsp_data_q[0]);
            end
        end
    endtask

    task automatic test_timeout();
        int cyc;
        int n;
        clear_logs();
        c_rd[0] = 1'b0; c_addr[0] = 24'h000200; c_data[0] = 32'h0BADF00D;
        drive_cmds(1);
        cyc = 0;
        while (pkt_cnt < 1 && cyc < 200) begin
            tick();
            cyc++;
        end
        n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 100) begin
            errors++;
            $display("FAIL tmo_cycles: %0d WAIT cycles, required 100", n);
        end
        checks++;
        if (err_tmo !== 1'b1) begin
            errors++;
            $display("FAIL tmo_pulse: err_tmo=%b, required 1", err_tmo);
        end
        tick();
        for (int j = 0; j < 8; j++) begin
            rx_stb = 1'b1;
            rx_din = 8'(j + 1);
            tick();
        end
        rx_stb = 1'b0;
        repeat (3) tick();
        checks++;
        if (err_tmo_cnt != 1 || err_len_cnt != 0 || rsp_rd_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_after: err_tmo=%0d err_len=%0d resp=%0d busy=%b, required 1 0 0 0",
                     err_tmo_cnt, err_len_cnt, rsp_rd_q.size(), busy);
        end
    endtask

    task automatic test_rst_mid();
        int cyc;
        logic [7:0] exp_b[8];
        exp_b = '{8'h00, 8'h00, 8'h04, 8'h56, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
        clear_logs();
        c_rd[0] = 1'b0; c_addr[0] = 24'hABCDEF; c_data[0] = 32'h01020304;
        drive_cmds(1);
        cyc = 0;
        while (tx_bytes.size() < 3 && cyc < 100) begin
            tick();
            cyc++;
        end
        rst = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if ({tx_stb, tx_end, tx_dout, cmd_ready, busy, resp_valid, err_len, err_tmo} !== 15'h0) begin
            errors++;
            $display("FAIL rst_mid: stb=%b end=%b dout=%h rdy=%b busy=%b rv=%b el=%b et=%b, required all 0",
                     tx_stb, tx_end, tx_dout, cmd_ready, busy, resp_valid, err_len, err_tmo);
        end
        tick();
        rst = 1'b0;
        tick();
        clear_logs();
        c_rd[0] = 1'b0; c_addr[0] = 24'h000456; c_data[0] = 32'hA5A5A5A5;
        fork
            drive_cmds(1);
            respond(1, 32'h0, -1);
        join
        repeat (3) tick();
        checks++;
        if (tx_bytes.size() != 8) begin
            errors++;
            $display("FAIL rst_clean_len: %0d bytes, required 8", tx_bytes.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                checks++;
                if (tx_bytes[j] !== exp_b[j] || tx_ends[j] !== (j == 7)) begin
                    errors++;
                    $display("FAIL rst_clean_byte%0d: %h end=%b, required %h end=%b", j, tx_bytes[j], tx_ends[j], exp_b[j], j == 7);
                end
            end
        end
        checks++;
        if (rsp_rd_q.size() != 1 || err_len_cnt != 0) begin
            errors++;
            $display("FAIL rst_clean_resp: resp=%0d err_len=%0d, required 1 0", rsp_rd_q.size(), err_len_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_back_to_back();
        test_stall();
        test_truncated();
        test_timeout();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
